sa_drain: RTL and testbench
===========================

SA_DRAIN -- requirements
Module: sa_drain

Interface
REQ-001 The block SHALL have parameter ROWS, default 4, meaning array rows, one east-edge result lane per row.
REQ-002 The block SHALL have parameter COLS, default 4, meaning array columns; base drain latency LAT = COLS steps.
REQ-003 The block SHALL have parameter RES_W, default 16, meaning result width per row, signed two's complement.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, meaning output FIFO entries, a power of two.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 The block SHALL have port step_valid, input, 1 bit: the same array-wide valid strobe driven into the PE grid.
REQ-008 The block SHALL have port conf, input, 1 bit: the array-wide weight-configuration flag.
REQ-009 The block SHALL have port row_res, input, ROWS*RES_W bits: east-edge partial sums, row r at bits [r*RES_W +: RES_W].
REQ-010 The block SHALL have port go, input, 1 bit: single-cycle job start.
REQ-011 The block SHALL have port num_vec, input, 8 bits: vectors in the job, sampled when go is accepted.
REQ-012 The block SHALL have port out_data, output, ROWS*RES_W bits: one aligned result vector, row order as row_res.
REQ-013 The block SHALL have port out_valid, input out_ready, 1 bit each: output valid/ready handshake.
REQ-014 The block SHALL have port busy, done, ovf, outputs, 1 bit each: job active, single-cycle job completion, sticky overflow.

Function
REQ-015 A step SHALL be a cycle with step_valid=1 and conf=0; cycles with conf=1 SHALL NOT be counted and SHALL NOT sample row_res.
REQ-016 The FSM SHALL have states IDLE and RUN; go in IDLE SHALL latch num_vec, clear the step counter s, and enter RUN; go in RUN SHALL be ignored.
REQ-017 In RUN, on step s, row r SHALL sample row_res lane r iff 0 <= s-LAT-r < num_vec; the sample belongs to vector k = s-LAT-r.
REQ-018 Row r samples SHALL pass through a skew line of ROWS-1-r steps, advancing only on steps, so all rows of vector k align at step k+LAT+ROWS-1.
REQ-019 Each aligned vector SHALL be written to the FIFO on the clock edge ending its aligning step; out_valid SHALL rise the following cycle when the FIFO was empty.
REQ-020 A FIFO pop SHALL occur when out_valid and out_ready are both 1; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-021 A push to a full FIFO without a same-cycle pop SHALL drop the vector and set ovf; ovf SHALL clear only on rst.
REQ-022 After vector num_vec-1 is pushed or dropped, the FSM SHALL pulse done for one cycle and return to IDLE; the FIFO SHALL keep draining.
REQ-023 When num_vec=0, go SHALL produce done on the next cycle with no pushes.
REQ-024 busy SHALL be 1 exactly in RUN; the step counter SHALL saturate at 255+LAT+ROWS and SHALL NOT wrap.

Reset
REQ-025 While rst=1 the block SHALL enter IDLE and clear the FIFO pointers, skew lines and counters, with out_valid=0, out_data=0, busy=0, done=0 and ovf=0.
REQ-026 rst asserted mid-job SHALL abort the job; no partial vector SHALL be emitted after reset.

Configuration
REQ-027 With SA_DRAIN_RELU_EN defined, each lane SHALL be clamped to 0 when negative at FIFO write.
REQ-028 With SA_DRAIN_RELU_EN undefined, lanes SHALL pass through unchanged.

Structure
REQ-029 RES_W-related constants and the FSM state encoding SHALL live in the shared package sa_pkg.
REQ-030 The output FIFO SHALL be a separate sub-module sa_fifo, parameterised by width and depth.

Verification
REQ-031 ROWS=COLS=4, num_vec=2, row r driven with 100*(s-4-r)+r on steps -> vectors {0,1,2,3} and {100,101,102,103} pushed at steps 7 and 8, then done.
REQ-032 Same job with conf=1 and step_valid=1 on every other cycle -> identical output, done delayed by the number of conf cycles.
REQ-033 out_ready=0 and num_vec=6 -> 4 vectors held, vectors 5 and 6 dropped, ovf=1, done still pulses.
REQ-034 rst pulsed at step 5 of a num_vec=3 job -> busy=0 and out_valid=0 after reset; a new job then runs cleanly.
REQ-035 num_vec=0 -> done one cycle after go, out_valid stays 0.
REQ-036 With SA_DRAIN_RELU_EN, lane values {-5,7,-1,0} -> output {0,7,0,0}; without the macro -> {-5,7,-1,0}.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array east-edge drain block:
// result-width defaults, job-length width, FSM encoding and step-counter bound.
package sa_pkg;

  localparam int RES_W_DEF = 16;  // default signed result width per row
  localparam int NVEC_W    = 8;   // width of the per-job vector count

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Largest step count a job can ever need; the counter parks here.
  function automatic int step_max(input int cols, input int rows);
    return (1 << NVEC_W) - 1 + cols + rows;
  endfunction

endpackage

// File: rtl/sa_fifo.sv
// Synchronous first-word-fall-through FIFO used to buffer aligned result
// vectors. DEPTH must be a power of two (>= 2). rdata reads 0 while empty.
module sa_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; the caller only pushes when there is room or a pop frees a slot.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are qualified by the pointers so they need no reset.
  always_ff @(posedge clk) begin
    // NOTE: the memory array is deliberately left out of reset; empty gates what reaches rdata.
    if (push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sa_drain.sv
// East-edge drain for a ROWS x COLS systolic array: samples each row's partial
// sums in its valid window, de-skews the rows into aligned vectors and queues
// them into an output FIFO with a valid/ready handshake.
// Optional build macro SA_DRAIN_RELU_EN: clamp negative lanes to 0 at FIFO write.
module sa_drain
  import sa_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int RES_W      = RES_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step_valid,
  input  logic                  conf,
  input  logic [ROWS*RES_W-1:0] row_res,
  input  logic                  go,
  input  logic [NVEC_W-1:0]     num_vec,
  output logic [ROWS*RES_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int LAT   = COLS;
  localparam int S_MAX = step_max(COLS, ROWS);
  localparam int CW    = $clog2(S_MAX + 1);
  localparam int ALIGN = LAT + ROWS - 1;   // step at which vector 0 is aligned

  state_t            state_q, state_d;
  logic [CW-1:0]     s_q, s_d;
  logic [NVEC_W-1:0] nvec_q, nvec_d;
  logic              done_q, done_d;
  logic              ovf_q;

  logic              step;
  logic              run_step;
  logic [ROWS-1:0]   in_win;
  logic              push_req;
  logic              last_vec;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push;

  logic [ROWS-1:0][RES_W-1:0] aligned;
  logic [ROWS-1:0][RES_W-1:0] wvec;

  assign step     = step_valid && !conf;
  assign run_step = (state_q == S_RUN) && step;

  // Per-row sampling window and push/last-vector decode for the current step.
  always_comb begin
    in_win   = '0;
    push_req = 1'b0;
    last_vec = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      in_win[r] = run_step && (int'(s_q) - LAT - r >= 0)
                           && (int'(s_q) - LAT - r < int'(nvec_q));
    end
    if (run_step && (int'(s_q) >= ALIGN) && (int'(s_q) - ALIGN < int'(nvec_q))) begin
      push_req = 1'b1;
      last_vec = (int'(s_q) - ALIGN == int'(nvec_q) - 1);
    end
  end

  // Row de-skew: row r waits ROWS-1-r steps so all lanes of a vector line up.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam int D = ROWS - 1 - r;
    logic [RES_W-1:0] lane_in;
    assign lane_in = in_win[r] ? row_res[r*RES_W +: RES_W] : '0;

    if (D == 0) begin : g_direct
      assign aligned[r] = lane_in;
    end else begin : g_skew
      logic [RES_W-1:0] sr [D];
      // Shift line advancing only on array steps during a job.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) sr[i] <= '0;
        end else if (run_step) begin
          sr[0] <= lane_in;
          for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[r] = sr[D-1];
    end

`ifdef SA_DRAIN_RELU_EN
    assign wvec[r] = aligned[r][RES_W-1] ? '0 : aligned[r];
`else
    assign wvec[r] = aligned[r];
`endif
  end

  assign pop  = out_valid && out_ready;
  assign push = push_req && (!fifo_full || pop);

  sa_fifo #(
    .WIDTH (ROWS*RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wvec),
    .pop   (pop),
    .rdata (out_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign ovf       = ovf_q;

  // Job FSM next-state: accept go in IDLE, count steps in RUN, finish on last vector.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d = state_q;
    s_d     = s_q;
    nvec_d  = nvec_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          nvec_d = num_vec;
          s_d    = '0;
          if (num_vec == '0) done_d  = 1'b1;
          else               state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (step && (s_q != CW'(S_MAX))) s_d = s_q + 1'b1;
        if (last_vec) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Job FSM state, counters and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      nvec_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      nvec_q  <= nvec_d;
      done_q  <= done_d;
      if (push_req && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_drain.sv
// Directed self-checking bench for sa_drain (ROWS=COLS=4, RES_W=16, depth 4).
module tb_sa_drain;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int RES_W = 16;
  localparam int W = ROWS*RES_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_valid;
  logic         conf;
  logic [W-1:0] row_res;
  logic         go;
  logic [7:0]   num_vec;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sa_drain #(.ROWS(ROWS), .COLS(COLS), .RES_W(RES_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .step_valid (step_valid),
    .conf       (conf),
    .row_res    (row_res),
    .go         (go),
    .num_vec    (num_vec),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row r at step s carries 100*(s-4-r)+r, i.e. 100*k+r for vector k.
  function automatic logic [W-1:0] lanes(input int s);
    logic [W-1:0] l;
    int v;
    for (int r = 0; r < ROWS; r++) begin
      v = 100*(s - COLS - r) + r;
      l[r*RES_W +: RES_W] = v[RES_W-1:0];
    end
    return l;
  endfunction

  function automatic logic [W-1:0] exp_vec(input int k);
    logic [W-1:0] l;
    int v;
    for (int r = 0; r < ROWS; r++) begin
      v = 100*k + r;
      l[r*RES_W +: RES_W] = v[RES_W-1:0];
    end
    return l;
  endfunction

  task automatic start_job(input logic [7:0] n);
    go = 1'b1; num_vec = n; step_valid = 1'b0; conf = 1'b0;
    tick();
    go = 1'b0;
  endtask

  task automatic do_step(input int s);
    step_valid = 1'b1; conf = 1'b0; row_res = lanes(s);
    tick();
    step_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int k0, input int n);
    out_ready = 1'b1;
    for (int k = k0; k < k0 + n; k++) begin
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_data"}, 64'(out_data), 64'(exp_vec(k)));
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_empty"}, 64'(out_valid), 64'd0);
  endtask

  logic [W-1:0] relu_exp;

  initial begin
    rst = 1'b1; step_valid = 1'b0; conf = 1'b0; row_res = '0;
    go = 1'b0; num_vec = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Basic job: two vectors, pushed at steps 7 and 8.
    start_job(8'd2);
    check("t1_busy", 64'(busy), 64'd1);
    for (int s = 0; s < 7; s++) do_step(s);
    check("t1_nopush_yet", 64'(out_valid), 64'd0);
    do_step(7);
    check("t1_valid_s7", 64'(out_valid), 64'd1);
    check("t1_done_s7", 64'(done), 64'd0);
    do_step(8);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);
    drain("t1", 0, 2);

    // Same job with a conf cycle between each step: data unchanged, done later.
    start_job(8'd2);
    for (int s = 0; s < 9; s++) begin
      if (s > 0) begin
        step_valid = 1'b1; conf = 1'b1; row_res = {4{16'hDEAD}};
        tick();
        check("t2_conf_no_done", 64'(done), 64'd0);
        check("t2_conf_busy", 64'(busy), 64'd1);
      end
      do_step(s);
    end
    conf = 1'b0;
    check("t2_done", 64'(done), 64'd1);
    drain("t2", 0, 2);

    // Output stalled, six vectors: four held, last two dropped, ovf set.
    start_job(8'd6);
    for (int s = 0; s < 11; s++) do_step(s);
    check("t3_ovf_before", 64'(ovf), 64'd0);
    do_step(11);
    check("t3_ovf_set", 64'(ovf), 64'd1);
    check("t3_done_early", 64'(done), 64'd0);
    do_step(12);
    check("t3_done", 64'(done), 64'd1);
    drain("t3", 0, 4);
    check("t3_ovf_sticky", 64'(ovf), 64'd1);

    // Reset at step 5 of a three-vector job aborts it and clears ovf.
    start_job(8'd3);
    for (int s = 0; s < 5; s++) do_step(s);
    rst = 1'b1; step_valid = 1'b1; row_res = lanes(5);
    tick();
    step_valid = 1'b0;
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_valid", 64'(out_valid), 64'd0);
    check("t4_rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();
    check("t4_idle_valid", 64'(out_valid), 64'd0);

    // New job of five vectors; at the full-FIFO push a same-cycle pop frees room.
    start_job(8'd5);
    for (int s = 0; s < 11; s++) do_step(s);
    check("t5_head", 64'(out_data), 64'(exp_vec(0)));
    out_ready = 1'b1;
    do_step(11);
    out_ready = 1'b0;
    check("t5_done", 64'(done), 64'd1);
    check("t5_no_ovf", 64'(ovf), 64'd0);
    drain("t5", 1, 4);

    // Zero-length job: done on the next cycle, never busy, nothing pushed.
    start_job(8'd0);
    check("t6_done", 64'(done), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    for (int s = 0; s < 10; s++) do_step(s);
    check("t6_done_pulse", 64'(done), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);

    // Negative lanes: clamped only in the ReLU build.
`ifdef SA_DRAIN_RELU_EN
    relu_exp = {16'd0, 16'd0, 16'd7, 16'd0};
`else
    relu_exp = {16'h0000, 16'hFFFF, 16'h0007, 16'hFFFB};
`endif
    start_job(8'd1);
    for (int s = 0; s < 8; s++) begin
      step_valid = 1'b1; conf = 1'b0;
      row_res = {16'h0000, 16'hFFFF, 16'h0007, 16'hFFFB};
      tick();
    end
    step_valid = 1'b0;
    check("t7_done", 64'(done), 64'd1);
    check("t7_valid", 64'(out_valid), 64'd1);
    check("t7_relu_data", 64'(out_data), 64'(relu_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
